// File: rtl/fft_stream_bridge.sv
// ---------------------------------------------------------------------------
// fft_stream_bridge
//
// Connects a valid/ready sample stream to an FFT working RAM and streams the
// transformed frame back out.
//   LOAD   : each input handshake writes one sample to RAM.
//   WAIT   : the bridge waits for the FFT core to raise i_CALC_END.
//   UNLOAD : RAM indices 0..N-1 are read in order through a 2-entry FIFO.
//
// Optional feature (compile-time macro BRIDGE_BIT_REVERSE_EN):
//   defined   - LOAD write address is k bit-reversed over log2(N) bits, and
//               only power-of-two frame lengths are accepted.
//   undefined - LOAD write address is k, and any 1 <= N <= 2**ADDR_WIDTH is
//               accepted.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_SAMPLES_NUMBER             frame length N, sampled at frame start
//   i_IN_DATA/VALID/LAST         input sample stream, o_IN_READY back-pressure
//   o_WRITE_ram, o_READ_ram      RAM strobes (never both high)
//   o_SAMPLE_INDEX_ram           RAM index, o_SAMPLE_ram write data
//   i_DATA_FROM_RAM              read data, one cycle after o_READ_ram
//   o_DATA_LOADED                one-cycle pulse in the first WAIT cycle
//   i_CALC_END                   FFT finished (level)
//   o_OUT_DATA/VALID/LAST        result stream, i_OUT_READY back-pressure
//   o_ERROR                      sticky frame error, cleared by a good start
//   o_state                      IDLE=0, LOAD=1, WAIT=2, UNLOAD=3
// ---------------------------------------------------------------------------
module fft_stream_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH:0]   i_SAMPLES_NUMBER,
  input  logic [DATA_WIDTH-1:0] i_IN_DATA,
  input  logic                  i_IN_VALID,
  input  logic                  i_IN_LAST,
  output logic                  o_IN_READY,
  output logic                  o_WRITE_ram,
  output logic                  o_READ_ram,
  output logic [ADDR_WIDTH-1:0] o_SAMPLE_INDEX_ram,
  output logic [DATA_WIDTH-1:0] o_SAMPLE_ram,
  input  logic [DATA_WIDTH-1:0] i_DATA_FROM_RAM,
  output logic                  o_DATA_LOADED,
  input  logic                  i_CALC_END,
  output logic [DATA_WIDTH-1:0] o_OUT_DATA,
  output logic                  o_OUT_VALID,
  output logic                  o_OUT_LAST,
  input  logic                  i_OUT_READY,
  output logic                  o_ERROR,
  output logic [1:0]            o_state
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] N_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_N = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_n;
  logic [ADDR_WIDTH:0]   n_r;
  logic [ADDR_WIDTH:0]   k_r;
  logic [ADDR_WIDTH:0]   rd_cnt_r;
  logic [ADDR_WIDTH:0]   out_cnt_r;
  logic [ADDR_WIDTH:0]   n_last_s;
  logic                  error_r;
  logic                  loaded_r;
  logic                  inflight_r;
  logic [DATA_WIDTH-1:0] fifo_mem_r [2];
  logic                  fifo_wr_r;
  logic                  fifo_rd_r;
  logic [1:0]            fifo_cnt_r;

  logic                  n_range_s;
  logic                  n_ok_s;
  logic                  start_ok_s;
  logic                  start_bad_s;
  logic                  load_done_s;
  logic                  load_abort_s;
  logic                  in_ready_s;
  logic                  wr_s;
  logic                  rd_s;
  logic                  out_valid_s;
  logic                  pop_s;
  logic                  push_s;
  logic [2:0]            occ_s;
  logic [ADDR_WIDTH-1:0] waddr_s;
  logic                  run_s;

  assign n_last_s  = n_r - ONE_N;
  assign n_range_s = (i_SAMPLES_NUMBER != {CW{1'b0}}) && (i_SAMPLES_NUMBER <= N_MAX);
  // Read data lands exactly one cycle after the strobe, so the in-flight flag
  // doubles as the FIFO push.
  assign push_s    = inflight_r;

`ifdef BRIDGE_BIT_REVERSE_EN
  localparam int LGW = $clog2(ADDR_WIDTH + 1);

  logic [LGW-1:0] lg_r;

  // log2 of a power-of-two frame length (position of its single set bit).
  function automatic logic [LGW-1:0] log2_pow2(input logic [ADDR_WIDTH:0] n);
    logic [LGW-1:0] lg;
    lg = {LGW{1'b0}};
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      if (n[i]) begin
        lg = LGW'(i);
      end
    end
    return lg;
  endfunction

  // Reverse the low 'lg' bits of v; bits at or above lg are zero.
  function automatic logic [ADDR_WIDTH-1:0] bit_reverse(input logic [ADDR_WIDTH-1:0] v,
                                                        input logic [LGW-1:0] lg);
    logic [ADDR_WIDTH-1:0] r;
    r = {ADDR_WIDTH{1'b0}};
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      for (int j = 0; j < ADDR_WIDTH; j++) begin
        if ((i < int'(lg)) && (j == int'(lg) - 1 - i)) begin
          r[i] = v[j];
        end
      end
    end
    return r;
  endfunction

  // Power-of-two test: exactly one bit set once the range check passed.
  assign n_ok_s  = n_range_s &&
                   ((i_SAMPLES_NUMBER & (i_SAMPLES_NUMBER - ONE_N)) == {CW{1'b0}});
  assign waddr_s = bit_reverse(k_r[ADDR_WIDTH-1:0], lg_r);

  // Frame log2 captured together with N at frame start.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lg_r <= {LGW{1'b0}};
    end else if (start_ok_s) begin
      lg_r <= log2_pow2(i_SAMPLES_NUMBER);
    end
  end
`else
  assign n_ok_s  = n_range_s;
  assign waddr_s = k_r[ADDR_WIDTH-1:0];
`endif

  // Next-state and strobe decode.
  always_comb begin
    state_n      = state_r;
    in_ready_s   = 1'b0;
    wr_s         = 1'b0;
    rd_s         = 1'b0;
    start_ok_s   = 1'b0;
    start_bad_s  = 1'b0;
    load_done_s  = 1'b0;
    load_abort_s = 1'b0;
    out_valid_s  = 1'b0;
    pop_s        = 1'b0;
    occ_s        = 3'd0;
    case (state_r)
      ST_IDLE: begin
        if (i_IN_VALID) begin
          if (n_ok_s) begin
            start_ok_s = 1'b1;
            state_n    = ST_LOAD;
          end else begin
            start_bad_s = 1'b1;
            state_n     = ST_IDLE;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOAD: begin
        in_ready_s = 1'b1;
        if (i_IN_VALID) begin
          wr_s = 1'b1;
          // Last expected sample wins over i_IN_LAST.
          if (k_r == n_last_s) begin
            load_done_s = 1'b1;
            state_n     = ST_WAIT;
          end else if (i_IN_LAST) begin
            load_abort_s = 1'b1;
            state_n      = ST_IDLE;
          end else begin
            state_n = ST_LOAD;
          end
        end else begin
          state_n = ST_LOAD;
        end
      end
      ST_WAIT: begin
        if (i_CALC_END) begin
          state_n = ST_UNLOAD;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_UNLOAD: begin
        out_valid_s = (fifo_cnt_r != 2'd0);
        pop_s       = out_valid_s & i_OUT_READY;
        // Occupancy counts the entry leaving this cycle as already gone;
        // otherwise the 2-entry FIFO would bubble every other sample.
        occ_s = {1'b0, fifo_cnt_r} - {2'b00, pop_s} + {2'b00, inflight_r};
        if ((rd_cnt_r != n_r) && (occ_s < 3'd2)) begin
          rd_s = 1'b1;
        end else begin
          rd_s = 1'b0;
        end
        if (pop_s && (out_cnt_r == n_last_s)) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_UNLOAD;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Frame control: state, counters, error flag, load-complete pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      n_r        <= {CW{1'b0}};
      k_r        <= {CW{1'b0}};
      rd_cnt_r   <= {CW{1'b0}};
      out_cnt_r  <= {CW{1'b0}};
      error_r    <= 1'b0;
      loaded_r   <= 1'b0;
      inflight_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      loaded_r   <= load_done_s;
      inflight_r <= rd_s;
      if (start_ok_s) begin
        n_r       <= i_SAMPLES_NUMBER;
        k_r       <= {CW{1'b0}};
        rd_cnt_r  <= {CW{1'b0}};
        out_cnt_r <= {CW{1'b0}};
        error_r   <= 1'b0;
      end else if (start_bad_s || load_abort_s) begin
        error_r <= 1'b1;
      end
      if (wr_s) begin
        k_r <= k_r + ONE_N;
      end
      if (rd_s) begin
        rd_cnt_r <= rd_cnt_r + ONE_N;
      end
      if (pop_s) begin
        out_cnt_r <= out_cnt_r + ONE_N;
      end
    end
  end

  // Two-entry output FIFO; flushed by reset and at every frame start.
  always_ff @(posedge i_clk) begin
    if (i_rst || start_ok_s) begin
      fifo_mem_r[0] <= {DATA_WIDTH{1'b0}};
      fifo_mem_r[1] <= {DATA_WIDTH{1'b0}};
      fifo_wr_r     <= 1'b0;
      fifo_rd_r     <= 1'b0;
      fifo_cnt_r    <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_mem_r[fifo_wr_r] <= i_DATA_FROM_RAM;
        fifo_wr_r             <= ~fifo_wr_r;
      end
      if (pop_s) begin
        fifo_rd_r <= ~fifo_rd_r;
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // All outputs are forced to zero while reset is asserted; data outputs are
  // also zero whenever their strobe/valid is low.
  assign run_s              = ~i_rst;
  assign o_IN_READY         = in_ready_s & run_s;
  assign o_WRITE_ram        = wr_s & run_s;
  assign o_READ_ram         = rd_s & run_s;
  assign o_SAMPLE_INDEX_ram = o_WRITE_ram ? waddr_s :
                              o_READ_ram  ? rd_cnt_r[ADDR_WIDTH-1:0] :
                                            {ADDR_WIDTH{1'b0}};
  assign o_SAMPLE_ram       = o_WRITE_ram ? i_IN_DATA : {DATA_WIDTH{1'b0}};
  assign o_DATA_LOADED      = loaded_r & run_s;
  assign o_OUT_VALID        = out_valid_s & run_s;
  assign o_OUT_DATA         = o_OUT_VALID ? fifo_mem_r[fifo_rd_r] : {DATA_WIDTH{1'b0}};
  assign o_OUT_LAST         = o_OUT_VALID & (out_cnt_r == n_last_s);
  assign o_ERROR            = error_r & run_s;
  assign o_state            = run_s ? state_r : ST_IDLE;

endmodule

// File: tb/tb_fft_stream_bridge.sv
// Self-checking bench for fft_stream_bridge (ADDR_WIDTH=4, DATA_WIDTH=32).
// A simple RAM sits behind the DUT; a behavioural model (expected write list,
// model RAM contents, expected output list) is checked once per cycle by tick().
module tb_fft_stream_bridge;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [AW:0]   i_SAMPLES_NUMBER = '0;
  logic [DW-1:0] i_IN_DATA = '0;
  logic          i_IN_VALID = 1'b0;
  logic          i_IN_LAST = 1'b0;
  logic          o_IN_READY;
  logic          o_WRITE_ram;
  logic          o_READ_ram;
  logic [AW-1:0] o_SAMPLE_INDEX_ram;
  logic [DW-1:0] o_SAMPLE_ram;
  logic [DW-1:0] ram_rdata = '0;
  logic          o_DATA_LOADED;
  logic          i_CALC_END = 1'b0;
  logic [DW-1:0] o_OUT_DATA;
  logic          o_OUT_VALID;
  logic          o_OUT_LAST;
  logic          i_OUT_READY = 1'b0;
  logic          o_ERROR;
  logic [1:0]    o_state;

  always #5 clk = ~clk;

  fft_stream_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_SAMPLES_NUMBER(i_SAMPLES_NUMBER),
    .i_IN_DATA(i_IN_DATA), .i_IN_VALID(i_IN_VALID), .i_IN_LAST(i_IN_LAST),
    .o_IN_READY(o_IN_READY), .o_WRITE_ram(o_WRITE_ram), .o_READ_ram(o_READ_ram),
    .o_SAMPLE_INDEX_ram(o_SAMPLE_INDEX_ram), .o_SAMPLE_ram(o_SAMPLE_ram),
    .i_DATA_FROM_RAM(ram_rdata), .o_DATA_LOADED(o_DATA_LOADED), .i_CALC_END(i_CALC_END),
    .o_OUT_DATA(o_OUT_DATA), .o_OUT_VALID(o_OUT_VALID), .o_OUT_LAST(o_OUT_LAST),
    .i_OUT_READY(i_OUT_READY), .o_ERROR(o_ERROR), .o_state(o_state)
  );

  // External RAM: read data valid one cycle after the strobe, garbage otherwise.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (o_WRITE_ram) ram[o_SAMPLE_INDEX_ram] <= o_SAMPLE_ram;
    if (o_READ_ram) ram_rdata <= ram[o_SAMPLE_INDEX_ram];
    else ram_rdata <= 32'hDEAD_BEEF;
  end

  int tests = 0;
  int fails = 0;

  // model state
  int            exp_wr_idx[$];
  logic [DW-1:0] exp_wr_dat[$];
  logic [DW-1:0] exp_out_dat[$];
  bit            exp_out_last[$];
  logic [DW-1:0] exp_ram [0:(1<<AW)-1];

  // observation state
  int            wr_cnt = 0, rd_cnt = 0, ld_cnt = 0, out_cnt = 0;
  int            cyc = 0, unl_cyc = 0, first_out_unl = 0;
  int            first_out_cyc = -1, last_out_cyc = -1;
  int            wr_log[$];
  logic [DW-1:0] out_log[$];
  bit            quiet_chk = 1'b0;
  bit            in_hs = 1'b0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] prev_dat = '0;
  bit            prev_last = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input string msg);
    tests++;
    fails++;
    $display("FAIL %s: %s", nm, msg);
  endtask

  // Write address the model expects for sample j of an n-sample frame.
  function automatic int exp_addr(input int j, input int n);
`ifdef BRIDGE_BIT_REVERSE_EN
    int lg = 0;
    int r = 0;
    while ((1 << lg) < n) lg++;
    for (int b = 0; b < lg; b++)
      if ((j & (1 << b)) != 0) r = r | (1 << (lg - 1 - b));
    return r;
`else
    return j + 0 * n;
`endif
  endfunction

  // One clock cycle: compare at the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    in_hs = i_IN_VALID && o_IN_READY;
    check("rw_exclusive", 64'(o_WRITE_ram & o_READ_ram), 64'd0);
    check("write_is_handshake", 64'(o_WRITE_ram), 64'(in_hs));
    if (o_WRITE_ram) begin
      wr_cnt++;
      wr_log.push_back(int'(o_SAMPLE_INDEX_ram));
      if (exp_wr_idx.size() == 0) begin
        fail_now("unexpected_write", $sformatf("idx %0d data 0x%0h", o_SAMPLE_INDEX_ram, o_SAMPLE_ram));
      end else begin
        check("write_index", 64'(o_SAMPLE_INDEX_ram), 64'(exp_wr_idx.pop_front()));
        check("write_data", 64'(o_SAMPLE_ram), 64'(exp_wr_dat.pop_front()));
      end
    end
    if (o_READ_ram) rd_cnt++;
    if (o_DATA_LOADED) ld_cnt++;
    if (o_state == 2'd3) unl_cyc++;
    if (stall_prev) begin
      check("stall_valid_held", 64'(o_OUT_VALID), 64'd1);
      check("stall_data_held", 64'(o_OUT_DATA), 64'(prev_dat));
      check("stall_last_held", 64'(o_OUT_LAST), 64'(prev_last));
    end
    if (o_OUT_VALID && first_out_unl == 0) first_out_unl = unl_cyc;
    if (o_OUT_VALID && i_OUT_READY) begin
      if (exp_out_dat.size() == 0) begin
        fail_now("unexpected_output", $sformatf("data 0x%0h", o_OUT_DATA));
      end else begin
        check("out_data", 64'(o_OUT_DATA), 64'(exp_out_dat.pop_front()));
        check("out_last", 64'(o_OUT_LAST), 64'(exp_out_last.pop_front()));
      end
      out_log.push_back(o_OUT_DATA);
      out_cnt++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
    end
    stall_prev = o_OUT_VALID && !i_OUT_READY;
    prev_dat   = o_OUT_DATA;
    prev_last  = o_OUT_LAST;
    if (quiet_chk) begin
      check("quiet_data_outputs", {o_SAMPLE_ram, o_OUT_DATA}, 64'd0);
      check("quiet_ctrl_outputs",
            64'({o_IN_READY, o_WRITE_ram, o_READ_ram, o_SAMPLE_INDEX_ram, o_DATA_LOADED,
                 o_OUT_VALID, o_OUT_LAST, o_ERROR, o_state}), 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  // One frame: load (optionally aborted by i_IN_LAST at last_at), wait
  // calc_delay WAIT cycles, unload with ready_mode 0 (always) or 1 (1,0,0,1);
  // rst_at >= 0 pulses reset once that many outputs have been taken.
  task automatic run_frame(input int n, input logic [DW-1:0] base, input int last_at,
                           input int calc_delay, input int ready_mode, input int rst_at);
    int n_send, j, g, wr0, rd0, ld0, out0;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    n_send = (last_at >= 0) ? last_at + 1 : n;
    wr0 = wr_cnt; rd0 = rd_cnt; ld0 = ld_cnt; out0 = out_cnt;
    unl_cyc = 0; first_out_unl = 0; first_out_cyc = -1; last_out_cyc = -1;
    wr_log.delete(); out_log.delete();
    for (int s = 0; s < n_send; s++) begin
      exp_wr_idx.push_back(exp_addr(s, n));
      exp_wr_dat.push_back(base + DW'(s));
      exp_ram[exp_addr(s, n)] = base + DW'(s);
    end
    i_SAMPLES_NUMBER = (AW+1)'(n);
    j = 0; g = 0;
    while (j < n_send && g < 100) begin
      i_IN_VALID = 1'b1;
      i_IN_DATA  = base + DW'(j);
      i_IN_LAST  = (j == last_at);
      tick();
      if (in_hs) j++;
      g++;
    end
    i_IN_VALID = 1'b0; i_IN_LAST = 1'b0; i_IN_DATA = '0;
    check("samples_accepted", 64'(j), 64'(n_send));
    if (last_at >= 0) begin
      tick(); tick();
      check("abort_state_idle", 64'(o_state), 64'd0);
      check("abort_error", 64'(o_ERROR), 64'd1);
      check("abort_no_loaded", 64'(ld_cnt - ld0), 64'd0);
      check("abort_writes", 64'(wr_cnt - wr0), 64'(n_send));
      return;
    end
    check("load_state_wait", 64'(o_state), 64'd2);
    check("load_error_clear", 64'(o_ERROR), 64'd0);
    for (int w = 0; w < calc_delay; w++) tick();
    i_CALC_END = 1'b1;
    tick();
    i_CALC_END = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_out_dat.push_back(exp_ram[i]);
      exp_out_last.push_back(i == n - 1);
    end
    g = 0;
    while ((out_cnt - out0) < n && g < 400) begin
      if (rst_at >= 0 && (out_cnt - out0) == rst_at) begin
        i_rst = 1'b1; quiet_chk = 1'b1;
        tick();
        exp_out_dat.delete(); exp_out_last.delete();
        i_rst = 1'b0;
        tick();
        check("rst_state_idle", 64'(o_state), 64'd0);
        tick();
        quiet_chk = 1'b0;
        check("rst_no_more_writes", 64'(wr_cnt - wr0), 64'(n));
        return;
      end
      i_OUT_READY = (ready_mode == 0) ? 1'b1 : pat[g % 4];
      tick();
      g++;
    end
    i_OUT_READY = 1'b0;
    check("frame_outputs", 64'(out_cnt - out0), 64'(n));
    check("frame_end_idle", 64'(o_state), 64'd0);
    check("frame_loaded_pulses", 64'(ld_cnt - ld0), 64'd1);
    check("frame_writes", 64'(wr_cnt - wr0), 64'(n));
    check("frame_reads", 64'(rd_cnt - rd0), 64'(n));
    check("first_valid_unload_cycle", 64'(first_out_unl), 64'd3);
    if (ready_mode == 0) check("no_bubbles", 64'(last_out_cyc - first_out_cyc), 64'(n - 1));
    check("wr_queue_drained", 64'(exp_wr_idx.size()), 64'd0);
    check("out_queue_drained", 64'(exp_out_dat.size()), 64'd0);
    tick();
  endtask

  // Bad frame length: error set, stays IDLE, no RAM strobes.
  task automatic bad_n(input int n);
    int wr0, rd0;
    wr0 = wr_cnt; rd0 = rd_cnt;
    i_SAMPLES_NUMBER = (AW+1)'(n);
    i_IN_VALID = 1'b1;
    i_IN_DATA  = 32'hBAD0_0000;
    tick(); tick(); tick();
    i_IN_VALID = 1'b0;
    check($sformatf("badn%0d_error", n), 64'(o_ERROR), 64'd1);
    check($sformatf("badn%0d_idle", n), 64'(o_state), 64'd0);
    check($sformatf("badn%0d_ready", n), 64'(o_IN_READY), 64'd0);
    check($sformatf("badn%0d_strobes", n), 64'((wr_cnt - wr0) + (rd_cnt - rd0)), 64'd0);
    tick();
  endtask

  initial begin
    int br [8];
    br = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int i = 0; i < (1 << AW); i++) exp_ram[i] = '0;

    // reset: every output zero during and after reset
    i_rst = 1'b1; quiet_chk = 1'b1;
    tick(); tick(); tick();
    i_rst = 1'b0;
    tick(); tick();
    quiet_chk = 1'b0;

    // N=8, 0x10..0x17, CALC_END after 5 WAIT cycles, ready held high
    run_frame(8, 32'h10, -1, 5, 0, -1);
    check("n8_out_count_lit", 64'(out_log.size()), 64'd8);
`ifndef BRIDGE_BIT_REVERSE_EN
    for (int i = 0; i < 8; i++) check("n8_write_idx_lit", 64'(wr_log[i]), 64'(i));
    check("n8_first_out_lit", 64'(out_log[0]), 64'h10);
    check("n8_last_out_lit", 64'(out_log[7]), 64'h17);
`endif

    // N=8 with i_IN_LAST on the 3rd sample, then a good frame clears o_ERROR
    run_frame(8, 32'h20, 2, 0, 0, -1);
    check("abort_writes_lit", 64'(wr_log.size()), 64'd3);
    run_frame(4, 32'h30, -1, 0, 0, -1);

    // N=16 with ready toggling 1,0,0,1
    run_frame(16, 32'h40, -1, 2, 1, -1);
    check("n16_out_count_lit", 64'(out_log.size()), 64'd16);

    // out-of-range lengths, then N=1
    bad_n(0);
    bad_n(17);
    run_frame(1, 32'h55, -1, 1, 0, -1);
    check("n1_writes_lit", 64'(wr_log.size()), 64'd1);
    check("n1_out_lit", 64'(out_log[0]), 64'h55);

`ifdef BRIDGE_BIT_REVERSE_EN
    run_frame(8, 32'h0, -1, 1, 0, -1);
    for (int i = 0; i < 8; i++) check("br_write_idx_lit", 64'(wr_log[i]), 64'(br[i]));
    for (int i = 0; i < 8; i++) check("br_out_lit", 64'(out_log[i]), 64'(br[i]));
    bad_n(6);
`else
    run_frame(6, 32'h60, -1, 1, 0, -1);
    check("n6_out_count_lit", 64'(out_log.size()), 64'd6);
    check("n6_last_out_lit", 64'(out_log[5]), 64'h65);
`endif

    // reset at output 4 of N=8, then a fresh frame
    run_frame(8, 32'h70, -1, 1, 0, 3);
    check("rst_outputs_taken_lit", 64'(out_log.size()), 64'd3);
    run_frame(8, 32'h80, -1, 1, 0, -1);
    check("post_rst_last_lit", 64'(out_log[7]), 64'h87);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
